// File: rtl/mult_pkg.sv
// Shared state type, default sizes and digit-count helper for the sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_e;

  localparam int MULT_WIDTH   = 64;
  localparam int MULT_DIGIT_W = 8;

  function automatic int digit_count(input int width, input int digit_w);
    return width / digit_w;
  endfunction

endpackage

// File: rtl/mult_digit.sv
// Combinational unsigned WIDTH x DIGIT_W multiplier; one partial product per call.
module mult_digit #(
  parameter int WIDTH   = 64,
  parameter int DIGIT_W = 8
) (
  input  logic [WIDTH-1:0]         i_a,
  input  logic [DIGIT_W-1:0]       i_b,
  output logic [WIDTH+DIGIT_W-1:0] o_product
);

  localparam int PW = WIDTH + DIGIT_W;

  assign o_product = PW'(i_a) * PW'(i_b);

endmodule

// File: rtl/mult_seq_unit.sv
// Sequential WIDTH x WIDTH multiplier consuming one DIGIT_W-bit multiplier digit per cycle.
// Optional build macro MULT_EARLY_TERM_EN: finish once all remaining multiplier digits are zero.
module mult_seq_unit
  import mult_pkg::*;
#(
  parameter int WIDTH   = MULT_WIDTH,
  parameter int DIGIT_W = MULT_DIGIT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               half_mode,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int NUM_DIGITS = digit_count(WIDTH, DIGIT_W);
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1);
  localparam int PW         = 2 * WIDTH;

  if (WIDTH % DIGIT_W != 0) begin : g_width_check
    $error("mult_seq_unit: WIDTH must be a multiple of DIGIT_W");
  end

  mult_state_e              r_state;
  mult_state_e              w_nextState;
  logic [WIDTH-1:0]         r_mcand;
  logic [WIDTH-1:0]         r_mplier;
  logic                     r_half;
  logic [PW-1:0]            r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [WIDTH+DIGIT_W-1:0] w_digitProd;
  logic [PW-1:0]            w_partial;
  logic                     w_accept;
  logic                     w_lastDigit;

  // The multiplier register shifts right each cycle, so its low digit is always the current one.
  mult_digit #(
    .WIDTH  (WIDTH),
    .DIGIT_W(DIGIT_W)
  ) u_digit (
    .i_a      (r_mcand),
    .i_b      (r_mplier[DIGIT_W-1:0]),
    .o_product(w_digitProd)
  );

  assign w_partial = PW'(w_digitProd) << (DIGIT_W * int'(r_cnt));

`ifdef MULT_EARLY_TERM_EN
  assign w_lastDigit = ((r_mplier >> DIGIT_W) == '0);
`else
  assign w_lastDigit = (r_cnt == CNT_W'(NUM_DIGITS - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b0;
    product     = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_nextState = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (w_lastDigit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        product    = r_half ? PW'(r_acc[WIDTH-1:0]) : r_acc;
        if (resp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operands are captured on acceptance; the accumulator only moves while in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_half   <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= multiplicand;
      r_mplier <= multiplier;
      r_half   <= half_mode;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == CALC) begin
      r_acc    <= r_acc + w_partial;
      r_mplier <= r_mplier >> DIGIT_W;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mult_seq_unit.sv
// Self-checking bench for mult_seq_unit: directed vector table, stall and reset sequences, random sweep.
module tb_mult_seq_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  multiplicand;
  logic [63:0]  multiplier;
  logic         half_mode;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] product;
  logic         busy;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic         half;
    logic [127:0] expProd;
  } vec_t;

  vec_t vecs[8];

  mult_seq_unit dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .half_mode   (half_mode),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .product     (product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Full 128-bit product, truncated to the low 64 bits in half mode.
  function automatic logic [127:0] refProduct(input logic [63:0] a, input logic [63:0] b, input logic half);
    logic [127:0] full;
    full = {64'd0, a} * {64'd0, b};
    return half ? {64'd0, full[63:0]} : full;
  endfunction

  // Cycles from accept edge to resp_valid: eight bytes, or up to the highest non-zero byte when terminating early.
  function automatic int expLatency(input logic [63:0] b);
`ifdef MULT_EARLY_TERM_EN
    int top;
    top = 1;
    for (int i = 0; i < 8; i++) begin
      if (b[i*8 +: 8] != 8'd0) top = i + 1;
    end
    return top;
`else
    return (b === 64'hx) ? 0 : 8;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Issues one request, measures latency, stalls the response for holdCycles, then consumes it.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic half,
                               input int holdCycles, output logic [127:0] prod, output int lat);
    int waitCnt;
    @(negedge clk);
    waitCnt = 0;
    while (!req_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) checkOutput("req_ready_timeout", 128'(req_ready), 128'd1);
    multiplicand = a;
    multiplier   = b;
    half_mode    = half;
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid    = 1'b0;
    multiplicand = {$urandom, $urandom};
    multiplier   = {$urandom, $urandom};
    half_mode    = 1'($urandom_range(0, 1));
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    prod = product;
    for (int i = 0; i < holdCycles; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      checkOutput("stall_product", product, prod);
      checkOutput("stall_resp_valid", 128'(resp_valid), 128'd1);
      checkOutput("stall_req_ready", 128'(req_ready), 128'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("release_resp_valid", 128'(resp_valid), 128'd0);
    checkOutput("release_req_ready", 128'(req_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] prod;
    int           lat;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         h;
    int           hold;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'h0000_0000_0000_0000_0000_0000_0000_0001};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0010, 1'b0, 128'h0000_0000_0000_0001_2345_6789_ABCD_EF00};
    vecs[3] = '{64'hDEAD_BEEF_0000_1234, 64'h0000_0000_0000_0000, 1'b0, 128'h0};
    vecs[4] = '{64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b0, 128'h0000_0000_0000_0000_8000_0000_0000_0000};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0002, 1'b0, 128'h0000_0000_0000_0001_0000_0000_0000_0000};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0002, 1'b1, 128'h0};
    vecs[7] = '{64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 1'b1, 128'h0000_0000_0000_0000_0000_0002_0000_0001};

    rst          = 1'b1;
    req_valid    = 1'b0;
    resp_ready   = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    half_mode    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 128'(req_ready), 128'd1);
    checkOutput("reset_resp_valid", 128'(resp_valid), 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_product", product, 128'd0);
    rst = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].half, 0, prod, lat);
      checkOutput($sformatf("vec%0d_product", i), prod, vecs[i].expProd);
      checkOutput($sformatf("vec%0d_latency", i), 128'(lat), 128'(expLatency(vecs[i].b)));
    end

    $display("[TB] backpressure: 20-cycle stall with competing requests");
    applyStimulus(64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 20, prod, lat);
    checkOutput("stall20_product", prod, refProduct(64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0));
    checkOutput("stall20_latency", 128'(lat), 128'(expLatency(64'h0F0F_0F0F_0F0F_0F0F)));

    $display("[TB] reset during CALC cycle 3");
    @(negedge clk);
    multiplicand = 64'hFFFF_FFFF_FFFF_FFFF;
    multiplier   = 64'hFFFF_FFFF_FFFF_FFFF;
    half_mode    = 1'b0;
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("calc_busy", 128'(busy), 128'd1);
    checkOutput("calc_req_ready", 128'(req_ready), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_resp_valid", 128'(resp_valid), 128'd0);
    checkOutput("midreset_product", product, 128'd0);
    checkOutput("midreset_busy", 128'(busy), 128'd0);
    checkOutput("midreset_req_ready", 128'(req_ready), 128'd1);
    applyStimulus(64'd3, 64'd5, 1'b0, 0, prod, lat);
    checkOutput("after_reset_product", prod, 128'd15);
    checkOutput("after_reset_latency", 128'(lat), 128'(expLatency(64'd5)));

    $display("[TB] random sweep");
    for (int n = 0; n < 1000; n++) begin
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      b    = b >> $urandom_range(0, 64);
      h    = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      applyStimulus(a, b, h, hold, prod, lat);
      checkOutput($sformatf("rand%0d_product", n), prod, refProduct(a, b, h));
      checkOutput($sformatf("rand%0d_latency", n), 128'(lat), 128'(expLatency(b)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
